// File: rtl/csr_unit.sv
// csr_unit -- machine-mode CSR file for the single-cycle RV core.
//
// Executes CSRRW/CSRRS/CSRRC, flags illegal accesses, handles trap entry and
// mret, produces the direct/vectored trap target and keeps a 64-bit minstret.
//
// Optional feature: define CSR_MCYCLE_EN to add the 64-bit mcycle counter at
// 0xB00 (and mcycleh at 0xB80 when XLEN=32). Without it those addresses are
// unknown.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   csr_op                   00 none, 01 RW, 10 RS, 11 RC
//   csr_no_write             RS/RC with rs1=x0: read only, no write
//   csr_addr, csr_wdata      CSR address and rs1/zimm operand
//   csr_rdata, csr_illegal   old CSR value and illegal flag (combinational)
//   trap, trap_cause, trap_epc   trap request, mcause value, trapping PC
//   trap_vector              trap target PC (combinational)
//   mret, mret_epc           mret request, current mepc
//   retire                   instruction retired this cycle
//   mie                      mstatus.MIE
module csr_unit #(
    parameter int XLEN   = 32,
    parameter int HARTID = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      csr_op,
    input  logic            csr_no_write,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_vector,
    input  logic            mret,
    output logic [XLEN-1:0] mret_epc,
    input  logic            retire,
    output logic            mie
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    // mstatus keeps only its two writable bits; MPP is a constant on read.
    logic            mie_reg;
    logic            mpie_reg;
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [XLEN-1:0] mscratch_reg;
    logic [63:0]     minstret_reg;
    logic [63:0]     minstret_next;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    logic [63:0]     mcycle_reg;
    logic [63:0]     mcycle_next;
`endif

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] wval;
    logic [XLEN-1:0] tvec_base;
    logic            known;
    logic            read_only;
    logic            csr_we;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie_reg;
        mstatus_val[3]     = mie_reg;
    end

    // Read decode: old value plus whether the address exists / is read-only.
    always_comb begin
        csr_rdata = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = mstatus_val;
            A_MTVEC:    csr_rdata = mtvec_reg;
            A_MSCRATCH: csr_rdata = mscratch_reg;
            A_MEPC:     csr_rdata = mepc_reg;
            A_MCAUSE:   csr_rdata = mcause_reg;
            A_MINSTRET: csr_rdata = minstret_reg[XLEN-1:0];
            A_MINSTRETH: begin
                // The high-half alias only exists on RV32.
                if (XLEN == 32) csr_rdata = XLEN'(minstret_reg[63:32]);
                else            known     = 1'b0;
            end
`ifdef CSR_MCYCLE_EN
            A_MCYCLE:   csr_rdata = mcycle_reg[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) csr_rdata = XLEN'(mcycle_reg[63:32]);
                else            known     = 1'b0;
            end
`endif
            12'hF11, 12'hF12, 12'hF13: read_only = 1'b1;
            A_MHARTID: begin
                csr_rdata = XLEN'(HARTID);
                read_only = 1'b1;
            end
            default:    known = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_wdata;
        endcase
    end

    assign csr_illegal = (csr_op != 2'b00) && (!known || (read_only && !csr_no_write));

    // Trap and mret outrank the CSR write, which is then dropped entirely.
    assign csr_we = (csr_op != 2'b00) && !csr_no_write && !csr_illegal && !trap && !mret;

    assign tvec_base = {mtvec_reg[XLEN-1:2], 2'b00};

    always_comb begin
        trap_vector = tvec_base;
        if (mtvec_reg[1:0] == 2'b01 && trap_cause[XLEN-1])
            trap_vector = tvec_base + {trap_cause[XLEN-3:0], 2'b00};
    end

    // A committed write to either counter half replaces that cycle's increment.
    always_comb begin
        minstret_next = minstret_reg;
        if (csr_we && csr_addr == A_MINSTRET) begin
            if (XLEN == 32) minstret_next[31:0] = wval[31:0];
            else            minstret_next       = 64'(wval);
        end else if (csr_we && csr_addr == A_MINSTRETH) begin
            minstret_next[63:32] = wval[31:0];
        end else if (retire && !trap) begin
            minstret_next = minstret_reg + 64'd1;
        end
    end

`ifdef CSR_MCYCLE_EN
    always_comb begin
        mcycle_next = mcycle_reg + 64'd1;
        if (csr_we && csr_addr == A_MCYCLE) begin
            mcycle_next = mcycle_reg;
            if (XLEN == 32) mcycle_next[31:0] = wval[31:0];
            else            mcycle_next       = 64'(wval);
        end else if (csr_we && csr_addr == A_MCYCLEH) begin
            mcycle_next         = mcycle_reg;
            mcycle_next[63:32]  = wval[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mcycle_reg <= '0;
        else     mcycle_reg <= mcycle_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mtvec_reg    <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mscratch_reg <= '0;
            minstret_reg <= '0;
        end else begin
            minstret_reg <= minstret_next;
            if (trap) begin
                mepc_reg   <= {trap_epc[XLEN-1:2], 2'b00};
                mcause_reg <= trap_cause;
                mpie_reg   <= mie_reg;
                mie_reg    <= 1'b0;
            end else if (mret) begin
                mie_reg    <= mpie_reg;
                mpie_reg   <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mie_reg  <= wval[3];
                        mpie_reg <= wval[7];
                    end
                    // Reserved modes 2/3 fall back to direct mode.
                    A_MTVEC:    mtvec_reg    <= {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
                    A_MSCRATCH: mscratch_reg <= wval;
                    A_MEPC:     mepc_reg     <= {wval[XLEN-1:2], 2'b00};
                    A_MCAUSE:   mcause_reg   <= wval;
                    default: ;
                endcase
            end
        end
    end

    assign mret_epc = mepc_reg;
    assign mie      = mie_reg;

endmodule

// File: tb/tb_csr_unit.sv
`timescale 1ns/1ps
module tb_csr_unit;
    localparam int XLEN   = 32;
    localparam int HARTID = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  csr_op;
    logic        csr_no_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_vector;
    logic        mret;
    logic [31:0] mret_epc;
    logic        retire;
    logic        mie;

    always #5 clk = ~clk;

    csr_unit #(.XLEN(XLEN), .HARTID(HARTID)) dut (
        .clk(clk), .rst(rst),
        .csr_op(csr_op), .csr_no_write(csr_no_write), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap(trap), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .trap_vector(trap_vector), .mret(mret), .mret_epc(mret_epc),
        .retire(retire), .mie(mie)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        csr_op = 2'b00; csr_no_write = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
        trap = 1'b0; trap_cause = 32'h0; trap_epc = 32'h0; mret = 1'b0; retire = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [1:0] op, input logic nw, input logic [11:0] a,
                          input logic [31:0] d);
        csr_op = op; csr_no_write = nw; csr_addr = a; csr_wdata = d;
    endtask

    // Side-effect-free read (RS with rs1=x0), checked combinationally.
    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        access(2'b10, 1'b1, a, 32'h0);
        #1;
        chk(name, csr_rdata, exp);
        csr_op = 2'b00;
    endtask

    // ---------------- reference model ----------------
    bit [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    bit [63:0] m_instret, m_cycle;

    function automatic void m_reset();
        m_mstatus = 32'h1800; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_instret = 0; m_cycle = 0;
    endfunction

    function automatic bit m_known(input bit [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB02, 12'hB82,
            12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
`ifdef CSR_MCYCLE_EN
            12'hB00, 12'hB80: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
`ifdef CSR_MCYCLE_EN
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
`endif
            12'hF14: return 32'(HARTID);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_illegal(input bit [1:0] op, input bit nw, input bit [11:0] a);
        if (op == 2'b00) return 1'b0;
        return !m_known(a) || (a[11:4] == 8'hF1 && !nw);
    endfunction

    function automatic bit [31:0] m_tvec(input bit [31:0] cause);
        bit [31:0] base;
        base = m_mtvec & ~32'h3;
        if (m_mtvec[1:0] == 2'd1 && cause[31]) return base + 32'd4 * (cause & 32'h7FFF_FFFF);
        return base;
    endfunction

    function automatic void m_step(input bit [1:0] op, input bit nw, input bit [11:0] a,
                                   input bit [31:0] wd, input bit tr, input bit [31:0] cause,
                                   input bit [31:0] epc, input bit mr, input bit ret);
        bit [31:0] old, nv;
        bit wrote_instret = 0, wrote_cycle = 0;
        old = m_read(a);
        if (tr) begin
            m_mepc    = epc & ~32'h3;
            m_mcause  = cause;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        end else if (mr) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (op != 2'b00 && !nw && !m_illegal(op, nw, a)) begin
            if (op == 2'b01)      nv = wd;
            else if (op == 2'b10) nv = old | wd;
            else                  nv = old & ~wd;
            case (a)
                12'h300: m_mstatus = 32'h1800 | (nv & 32'h88);
                12'h305: m_mtvec = (nv[1:0] > 2'd1) ? (nv & ~32'h3) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'hB02: begin m_instret[31:0] = nv; wrote_instret = 1; end
                12'hB82: begin m_instret[63:32] = nv; wrote_instret = 1; end
`ifdef CSR_MCYCLE_EN
                12'hB00: begin m_cycle[31:0] = nv; wrote_cycle = 1; end
                12'hB80: begin m_cycle[63:32] = nv; wrote_cycle = 1; end
`endif
                default: ;
            endcase
        end
        if (!wrote_instret && ret && !tr) m_instret = m_instret + 64'd1;
        if (!wrote_cycle) m_cycle = m_cycle + 64'd1;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic        nw;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[21];
    logic [11:0] addr_pool[15];

    initial begin
        vecs[0]  = '{2'b10, 1'b1, 12'h300, 32'h0,          32'h1800,     1'b0};
        vecs[1]  = '{2'b10, 1'b1, 12'hF14, 32'h0,          32'h5,        1'b0};
        vecs[2]  = '{2'b01, 1'b0, 12'h305, 32'h8000_0001,  32'h0,        1'b0};
        vecs[3]  = '{2'b10, 1'b1, 12'h305, 32'h0,          32'h8000_0001,1'b0};
        vecs[4]  = '{2'b01, 1'b0, 12'hF11, 32'h1,          32'h0,        1'b1};
        vecs[5]  = '{2'b01, 1'b0, 12'h7C0, 32'h1234_5678,  32'h0,        1'b1};
        vecs[6]  = '{2'b10, 1'b1, 12'h7C0, 32'h0,          32'h0,        1'b1};
        vecs[7]  = '{2'b01, 1'b0, 12'h340, 32'h55,         32'h0,        1'b0};
        vecs[8]  = '{2'b10, 1'b1, 12'h340, 32'h0,          32'h55,       1'b0};
        vecs[9]  = '{2'b10, 1'b1, 12'hF12, 32'h0,          32'h0,        1'b0};
        vecs[10] = '{2'b11, 1'b0, 12'h340, 32'h5,          32'h55,       1'b0};
        vecs[11] = '{2'b10, 1'b0, 12'h340, 32'h100,        32'h50,       1'b0};
        vecs[12] = '{2'b10, 1'b1, 12'h340, 32'h0,          32'h150,      1'b0};
        vecs[13] = '{2'b01, 1'b0, 12'h300, 32'hFFFF_FFFF,  32'h1800,     1'b0};
        vecs[14] = '{2'b10, 1'b1, 12'h300, 32'h0,          32'h1888,     1'b0};
        vecs[15] = '{2'b01, 1'b0, 12'h341, 32'h1237,       32'h0,        1'b0};
        vecs[16] = '{2'b10, 1'b1, 12'h341, 32'h0,          32'h1234,     1'b0};
        vecs[17] = '{2'b01, 1'b0, 12'hF14, 32'h0,          32'h5,        1'b1};
        vecs[18] = '{2'b10, 1'b1, 12'hB82, 32'h0,          32'h0,        1'b0};
        vecs[19] = '{2'b11, 1'b1, 12'h342, 32'hF,          32'h0,        1'b0};
        vecs[20] = '{2'b00, 1'b0, 12'h7C0, 32'h0,          32'h0,        1'b0};

        addr_pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB02, 12'hB82,
                      12'hB00, 12'hB80, 12'hF11, 12'hF13, 12'hF14, 12'hF10, 12'h7C0, 12'h301};

        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Table phase
        for (int i = 0; i < 21; i++) begin
            access(vecs[i].op, vecs[i].nw, vecs[i].addr, vecs[i].wdata);
            #1;
            $display("[TB] vec %0d op=%0d addr=%h rdata=%h ill=%0b",
                     i, vecs[i].op, vecs[i].addr, csr_rdata, csr_illegal);
            chk($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_ill", i), csr_illegal, vecs[i].exp_ill);
            tick();
            set_idle();
        end

        // Trap vectoring; a CSR write alongside a trap is dropped
        rst = 1'b1; tick(); rst = 1'b0;
        access(2'b01, 1'b0, 12'h305, 32'h8000_0001); tick(); set_idle();
        access(2'b01, 1'b0, 12'h340, 32'h55);
        trap = 1'b1; trap_cause = 32'h8000_0007; trap_epc = 32'h8000_0010;
        #1;
        $display("[TB] seq trap vectored tvec=%h", trap_vector);
        chk("tvec_vectored", trap_vector, 32'h8000_001C);
        chk("trap_wr_ill", csr_illegal, 1'b0);
        tick(); set_idle();
        rd("mscratch_after_trap", 12'h340, 32'h0);
        trap = 1'b1; trap_cause = 32'h2;
        #1;
        $display("[TB] seq trap exception tvec=%h", trap_vector);
        chk("tvec_exception", trap_vector, 32'h8000_0000);
        tick(); set_idle();
        rd("mcause", 12'h342, 32'h2);

        // Trap entry / mret with MIE stacking
        access(2'b01, 1'b0, 12'h300, 32'h8); tick(); set_idle();
        chk("mie_set", mie, 1'b1);
        trap = 1'b1; trap_cause = 32'h2; trap_epc = 32'h8000_0102;
        tick(); set_idle();
        $display("[TB] seq trap entry mie=%0b mret_epc=%h", mie, mret_epc);
        chk("mie_after_trap", mie, 1'b0);
        rd("mstatus_after_trap", 12'h300, 32'h1880);
        rd("mepc_after_trap", 12'h341, 32'h8000_0100);
        chk("mret_epc", mret_epc, 32'h8000_0100);
        mret = 1'b1; access(2'b01, 1'b0, 12'h340, 32'h77);
        tick(); set_idle();
        $display("[TB] seq mret mie=%0b", mie);
        chk("mie_after_mret", mie, 1'b1);
        rd("mstatus_after_mret", 12'h300, 32'h1888);
        rd("mscratch_after_mret", 12'h340, 32'h0);
        chk("mret_epc_hold", mret_epc, 32'h8000_0100);
        access(2'b01, 1'b0, 12'hF11, 32'h1); trap = 1'b1;
        #1;
        chk("ill_during_trap", csr_illegal, 1'b1);
        set_idle();

        // minstret carry, trap suppression, write-beats-increment
        access(2'b01, 1'b0, 12'hB02, 32'hFFFF_FFFF); tick(); set_idle();
        retire = 1'b1; tick(); set_idle();
        $display("[TB] seq minstret carry");
        rd("instret_lo_carry", 12'hB02, 32'h0);
        rd("instret_hi_carry", 12'hB82, 32'h1);
        retire = 1'b1; trap = 1'b1; trap_cause = 32'h3; tick(); set_idle();
        rd("instret_trap_noinc", 12'hB02, 32'h0);
        access(2'b01, 1'b0, 12'hB02, 32'hFF); tick(); set_idle();
        access(2'b11, 1'b0, 12'hB02, 32'hF); retire = 1'b1;
        #1;
        chk("instret_rc_old", csr_rdata, 32'hFF);
        tick(); set_idle();
        rd("instret_rc_lo", 12'hB02, 32'hF0);
        rd("instret_rc_hi", 12'hB82, 32'h1);
        access(2'b01, 1'b0, 12'hB82, 32'h7); retire = 1'b1; tick(); set_idle();
        rd("instret_hiwr_lo", 12'hB02, 32'hF0);
        rd("instret_hiwr_hi", 12'hB82, 32'h7);
        access(2'b01, 1'b0, 12'hB82, 32'hFFFF_FFFF); tick();
        access(2'b01, 1'b0, 12'hB02, 32'hFFFF_FFFF); tick(); set_idle();
        retire = 1'b1; tick(); set_idle();
        rd("instret_wrap_lo", 12'hB02, 32'h0);
        rd("instret_wrap_hi", 12'hB82, 32'h0);

        // Reset discards a concurrent write and trap
        rst = 1'b1; access(2'b01, 1'b0, 12'h340, 32'hAA);
        trap = 1'b1; trap_epc = 32'h1000;
        tick(); rst = 1'b0; set_idle();
        $display("[TB] seq reset discard");
        rd("rst_mscratch", 12'h340, 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h1800);

        // Optional mcycle counter
`ifdef CSR_MCYCLE_EN
        rst = 1'b1; set_idle(); tick(); rst = 1'b0;
        repeat (10) @(posedge clk);
        rd("mcycle_10", 12'hB00, 32'd10);
        rd("mcycleh_0", 12'hB80, 32'h0);
`else
        access(2'b10, 1'b1, 12'hB00, 32'h0);
        #1;
        chk("mcycle_absent_ill", csr_illegal, 1'b1);
        chk("mcycle_absent_rdata", csr_rdata, 32'h0);
        access(2'b10, 1'b1, 12'hB80, 32'h0);
        #1;
        chk("mcycleh_absent_ill", csr_illegal, 1'b1);
        set_idle();
`endif

        // Randomized run against the reference model
        rst = 1'b1; set_idle(); tick(); rst = 1'b0;
        m_reset();
        for (int n = 0; n < 400; n++) begin
            csr_op       = 2'($urandom_range(0, 3));
            csr_no_write = ($urandom_range(0, 3) == 0);
            csr_addr     = addr_pool[$urandom_range(0, 14)];
            csr_wdata    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                       : $urandom;
            trap         = ($urandom_range(0, 9) == 0);
            trap_cause   = $urandom & 32'h8000_00FF;
            trap_epc     = $urandom;
            mret         = ($urandom_range(0, 9) == 0);
            retire       = ($urandom_range(0, 1) == 1);
            #1;
            $display("[TB] rnd %0d op=%0d nw=%0b addr=%h tr=%0b mr=%0b rdata=%h ill=%0b",
                     n, csr_op, csr_no_write, csr_addr, trap, mret, csr_rdata, csr_illegal);
            chk("rnd_rdata", csr_rdata, m_read(csr_addr));
            chk("rnd_ill", csr_illegal, m_illegal(csr_op, csr_no_write, csr_addr));
            chk("rnd_tvec", trap_vector, m_tvec(trap_cause));
            chk("rnd_mepc", mret_epc, m_mepc);
            chk("rnd_mie", mie, m_mstatus[3]);
            @(posedge clk);
            m_step(csr_op, csr_no_write, csr_addr, csr_wdata, trap, trap_cause,
                   trap_epc, mret, retire);
            #1;
        end
        set_idle();
        rd("rnd_final_instret_lo", 12'hB02, m_instret[31:0]);
        rd("rnd_final_instret_hi", 12'hB82, m_instret[63:32]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR file for the single-cycle RV core, sitting beside the register file in the execute stage.
- Executes CSRRW/CSRRS/CSRRC read-modify-write and raises illegal-CSR on unknown or read-only writes.
- Handles trap entry and mret, supports direct/vectored mtvec, and maintains a 64-bit minstret counter.
- XLEN-parametrised: 32 or 64.

Parameters:
XLEN, 32, data width; legal values 32 or 64
HARTID, 0, value returned by mhartid

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
csr_op  input  2  00 none, 01 RW, 10 RS, 11 RC
csr_no_write  input  1  RS/RC with rs1=x0: read only, no write, no illegal-on-RO
csr_addr  input  12  CSR address
csr_wdata  input  XLEN  rs1 value / zimm
csr_rdata  output  XLEN  old CSR value (combinational)
csr_illegal  output  1  access illegal this cycle (combinational)
trap  input  1  take trap this cycle
trap_cause  input  XLEN  mcause value; MSB=1 means interrupt
trap_epc  input  XLEN  PC of the trapping instruction
trap_vector  output  XLEN  trap target PC (combinational)
mret  input  1  mret executing
mret_epc  output  XLEN  current mepc
retire  input  1  instruction retired this cycle
mie  output  1  mstatus.MIE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - mstatus = 0x1800 (MPP=11, all else 0).
  - mtvec, mepc, mcause, mscratch = 0.
  - Counters = 0.
  - Reset while a trap, mret or CSR write is presented discards that operation.
- Address map:
  - 0x300 mstatus, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause.
  - 0xB02 minstret, 0xB82 minstreth (XLEN=32 only).
  - 0xF11–0xF13 read-only 0; 0xF14 mhartid = HARTID.
- Read:
  - csr_rdata is the pre-update value of the addressed CSR.
  - Unknown address: csr_rdata = 0.
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - Committed at the next edge when csr_op != 0, csr_no_write = 0, and the access is not illegal.
- csr_illegal = 1 when csr_op != 0 and any of:
  - unknown address;
  - XLEN=64 and a *h counter address;
  - a write (csr_no_write = 0) to 0xF1x.
  - An illegal access changes no state.
- Field masks:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; MPP always reads 11; other bits read 0.
  - mepc: bits [1:0] always read 0.
  - mtvec: bits [1:0] = MODE. MODE 0 direct, 1 vectored; MODE 2/3 writes store 0.
- Trap (trap = 1):
  - mepc <= trap_epc & ~3; mcause <= trap_cause.
  - MPIE <= MIE; MIE <= 0.
  - trap_vector = base + 4*cause[XLEN-2:0] when MODE=1 and cause MSB=1; otherwise base.
  - base = {mtvec[XLEN-1:2], 2'b00}.
- mret: MIE <= MPIE; MPIE <= 1.
- Priority (same cycle): rst > trap > mret > CSR write.
  - A lower-priority event in the same cycle is dropped entirely.
  - csr_illegal is still reported combinationally.
- minstret:
  - 64-bit; increments by 1 when retire = 1 and trap = 0.
  - Wraps from 2^64-1 to 0.
  - A CSR write to either half that cycle wins: the written half takes the write value, the other half holds, and there is no increment.
  - XLEN=64: 0xB02 accesses the full 64 bits.
  - Carry from the low half into the high half occurs in the same cycle.

Optional Feature:
- Macro CSR_MCYCLE_EN.
- Defined:
  - Adds 64-bit mcycle at 0xB00 (and mcycleh at 0xB80 when XLEN=32).
  - Increments every cycle after reset.
  - Write rules match minstret, except the increment happens regardless of trap.
- Undefined: 0xB00/0xB80 are unknown addresses, so rdata = 0 and csr_illegal = 1.

Test Plan:
- Reset, then read 0x300 with RS and csr_no_write=1 -> rdata 0x1800, illegal 0. Read 0xF14 -> HARTID.
- RW 0x305 = 0x8000_0001. Then trap with cause 0x8000_0007 -> trap_vector 0x8000_001C. Trap with cause 0x0000_0002 -> 0x8000_0000.
- MIE=1; trap with epc 0x8000_0102 -> mepc reads 0x8000_0100, MIE 0, MPIE 1. Then mret -> MIE 1, MPIE 1, mret_epc 0x8000_0100.
- Same cycle: trap plus RW 0x340=0x55 -> mscratch unchanged. RW 0xF11 -> illegal 1. RW 0x7C0 -> illegal 1, rdata 0, no state change.
- minstret low = 0xFFFF_FFFF, retire=1 -> low 0, high +1. retire with trap=1 -> no increment. RC 0xB02 with 0xF in the same cycle as retire -> low = old & ~0xF, no increment.
- CSR_MCYCLE_EN defined: mcycle reads N after N cycles following reset release. Undefined: 0xB00 -> illegal 1.
